// File: rtl/difftest_commit_sink.sv
// Difftest commit sink: buffers per-cycle commit bundles in a small FIFO and
// drains them as a serial, sequence-numbered record stream with valid/ready.
module difftest_commit_sink #(
  parameter int CONFIG_DW             = 32,
  parameter int CONFIG_P_COMMIT_WIDTH = 1,
  parameter int CONFIG_PC_W           = 30,
  parameter int CONFIG_INSN_DW        = 32,
  parameter int CONFIG_LRF_AW         = 5,
  parameter int CONFIG_P_FIFO_DEPTH   = 2,
  localparam int CW = 1 << CONFIG_P_COMMIT_WIDTH
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [CW-1:0]                   i_valid,
  input  logic [CONFIG_PC_W*CW-1:0]       i_pc,
  input  logic [CONFIG_INSN_DW*CW-1:0]    i_insn,
  input  logic [CW-1:0]                   i_wen,
  input  logic [CONFIG_LRF_AW*CW-1:0]     i_wnum,
  input  logic [CONFIG_DW*CW-1:0]         i_wdata,
  input  logic                            i_excp,
  input  logic [7:0]                      i_excp_vect,
  output logic                            o_valid,
  input  logic                            o_ready,
  output logic [CONFIG_PC_W-1:0]          o_pc,
  output logic [CONFIG_INSN_DW-1:0]       o_insn,
  output logic                            o_wen,
  output logic [CONFIG_LRF_AW-1:0]        o_wnum,
  output logic [CONFIG_DW-1:0]            o_wdata,
  output logic                            o_excp,
  output logic [7:0]                      o_excp_vect,
  output logic [31:0]                     o_seq,
  output logic                            o_overflow,
  output logic                            o_gap_err
);

  localparam int DEPTH = 1 << CONFIG_P_FIFO_DEPTH;
  localparam int PA    = CONFIG_P_FIFO_DEPTH;
  localparam int SW    = (CONFIG_P_COMMIT_WIDTH > 0) ? CONFIG_P_COMMIT_WIDTH : 1;
  localparam int PC_W  = CONFIG_PC_W;
  localparam int IN_W  = CONFIG_INSN_DW;
  localparam int RA_W  = CONFIG_LRF_AW;
  localparam int DW    = CONFIG_DW;

  // Bundle storage: data only, never reset; occupancy is tracked by count.
  logic [CW-1:0]      mem_valid [DEPTH];
  logic [PC_W*CW-1:0] mem_pc    [DEPTH];
  logic [IN_W*CW-1:0] mem_insn  [DEPTH];
  logic [CW-1:0]      mem_wen   [DEPTH];
  logic [RA_W*CW-1:0] mem_wnum  [DEPTH];
  logic [DW*CW-1:0]   mem_wdata [DEPTH];
  logic               mem_excp  [DEPTH];
  logic [7:0]         mem_vect  [DEPTH];

  logic [PA-1:0] wr_ptr, rd_ptr;
  logic [PA:0]   count;
  logic [CW-1:0] done;
  logic          excp_done;
  logic [31:0]   seq;
  logic          overflow, gap_err;

  logic          in_any, full, push, drop, gap;
  logic [CW-1:0] pend, sel_mask;
  logic [SW-1:0] sel;
  logic          has_slot, excp_pend, rec_valid, xfer, last, pop;
  logic [PC_W-1:0] sel_pc;
  logic [IN_W-1:0] sel_insn;
  logic            sel_wen;
  logic [RA_W-1:0] sel_wnum;
  logic [DW-1:0]   sel_wdata;

  assign in_any = (|i_valid) | i_excp;
  assign full   = (count == (PA+1)'(DEPTH));
  assign push   = in_any & ~full;
  assign drop   = in_any & full;
  // A contiguous valid mask is of the form 2^n-1, so v & (v+1) is zero.
  assign gap    = |(i_valid & (i_valid + CW'(1)));

  // Head slot selection: lowest still-pending valid slot wins.
  always_comb begin
    pend      = mem_valid[rd_ptr] & ~done;
    sel       = '0;
    sel_pc    = '0;
    sel_insn  = '0;
    sel_wen   = 1'b0;
    sel_wnum  = '0;
    sel_wdata = '0;
    for (int k = CW-1; k >= 0; k--) begin
      if (pend[k]) begin
        sel       = SW'(k);
        sel_pc    = mem_pc[rd_ptr][k*PC_W +: PC_W];
        sel_insn  = mem_insn[rd_ptr][k*IN_W +: IN_W];
        sel_wen   = mem_wen[rd_ptr][k];
        sel_wnum  = mem_wnum[rd_ptr][k*RA_W +: RA_W];
        sel_wdata = mem_wdata[rd_ptr][k*DW +: DW];
      end
    end
    sel_mask      = '0;
    sel_mask[sel] = 1'b1;
  end

  assign has_slot  = |pend;
  assign excp_pend = mem_excp[rd_ptr] & ~excp_done;
  assign rec_valid = (count != '0) & (has_slot | excp_pend);
  assign xfer      = rec_valid & o_ready;
  assign last      = has_slot ? (((pend & ~sel_mask) == '0) & ~excp_pend) : 1'b1;
  assign pop       = xfer & last;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      done      <= '0;
      excp_done <= 1'b0;
      seq       <= '0;
      overflow  <= 1'b0;
      gap_err   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (pop) begin
        done      <= '0;
        excp_done <= 1'b0;
      end else if (xfer) begin
        if (has_slot) done <= done | sel_mask;
        else          excp_done <= 1'b1;
      end
      if (xfer) seq      <= seq + 32'd1;
      if (drop) overflow <= 1'b1;
      if (gap)  gap_err  <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_valid[wr_ptr] <= i_valid;
      mem_pc[wr_ptr]    <= i_pc;
      mem_insn[wr_ptr]  <= i_insn;
      mem_wen[wr_ptr]   <= i_wen;
      mem_wnum[wr_ptr]  <= i_wnum;
      mem_wdata[wr_ptr] <= i_wdata;
      mem_excp[wr_ptr]  <= i_excp;
      mem_vect[wr_ptr]  <= i_excp_vect;
    end
  end

  // Record output: zeroed whenever nothing is presented.
  always_comb begin
    o_valid     = rec_valid;
    o_pc        = '0;
    o_insn      = '0;
    o_wen       = 1'b0;
    o_wnum      = '0;
    o_wdata     = '0;
    o_excp      = 1'b0;
    o_excp_vect = '0;
    if (rec_valid) begin
      if (has_slot) begin
        o_pc    = sel_pc;
        o_insn  = sel_insn;
        o_wen   = sel_wen;
        o_wnum  = sel_wnum;
        o_wdata = sel_wdata;
      end else begin
        o_pc        = mem_pc[rd_ptr][PC_W-1:0];
        o_excp      = 1'b1;
        o_excp_vect = mem_vect[rd_ptr];
      end
    end
  end

  assign o_seq      = seq;
  assign o_overflow = overflow;
  assign o_gap_err  = gap_err;

endmodule

// File: tb/tb_difftest_commit_sink.sv
// Scoreboard bench for difftest_commit_sink: expected records are queued when
// bundles are driven and compared as the sink hands them over.
module tb_difftest_commit_sink;

  logic        clk, rst;
  logic [1:0]  i_valid;
  logic [59:0] i_pc;
  logic [63:0] i_insn;
  logic [1:0]  i_wen;
  logic [9:0]  i_wnum;
  logic [63:0] i_wdata;
  logic        i_excp;
  logic [7:0]  i_excp_vect;
  logic        o_valid, o_ready;
  logic [29:0] o_pc;
  logic [31:0] o_insn;
  logic        o_wen;
  logic [4:0]  o_wnum;
  logic [31:0] o_wdata;
  logic        o_excp;
  logic [7:0]  o_excp_vect;
  logic [31:0] o_seq;
  logic        o_overflow, o_gap_err;

  difftest_commit_sink dut (
    .clk(clk), .rst(rst),
    .i_valid(i_valid), .i_pc(i_pc), .i_insn(i_insn), .i_wen(i_wen),
    .i_wnum(i_wnum), .i_wdata(i_wdata), .i_excp(i_excp), .i_excp_vect(i_excp_vect),
    .o_valid(o_valid), .o_ready(o_ready), .o_pc(o_pc), .o_insn(o_insn),
    .o_wen(o_wen), .o_wnum(o_wnum), .o_wdata(o_wdata), .o_excp(o_excp),
    .o_excp_vect(o_excp_vect), .o_seq(o_seq), .o_overflow(o_overflow),
    .o_gap_err(o_gap_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [29:0] pc;
    logic [31:0] insn;
    logic        wen;
    logic [4:0]  wnum;
    logic [31:0] wdata;
    logic        excp;
    logic [7:0]  vect;
  } rec_t;

  rec_t        exp_q[$];
  rec_t        mon_e;
  logic [31:0] mdl_seq;
  int          nchecks = 0;
  int          nerrs   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchecks++;
    if (obs !== exp) begin
      nerrs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && o_valid && o_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rec", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("rec_pc",    o_pc,        mon_e.pc);
        check("rec_insn",  o_insn,      mon_e.insn);
        check("rec_wen",   o_wen,       mon_e.wen);
        check("rec_wnum",  o_wnum,      mon_e.wnum);
        check("rec_wdata", o_wdata,     mon_e.wdata);
        check("rec_excp",  o_excp,      mon_e.excp);
        check("rec_vect",  o_excp_vect, mon_e.vect);
      end
      check("rec_seq", o_seq, mdl_seq);
      mdl_seq = mdl_seq + 32'd1;
    end
  end

  task automatic send(input logic [1:0] v, input logic [29:0] pc0, input logic [29:0] pc1,
                      input logic [31:0] insn0, input logic [31:0] insn1, input logic [1:0] wen,
                      input logic [4:0] wn0, input logic [4:0] wn1,
                      input logic [31:0] wd0, input logic [31:0] wd1,
                      input logic excp, input logic [7:0] vect, input bit accept);
    rec_t r;
    i_valid = v; i_pc = {pc1, pc0}; i_insn = {insn1, insn0}; i_wen = wen;
    i_wnum = {wn1, wn0}; i_wdata = {wd1, wd0}; i_excp = excp; i_excp_vect = vect;
    if (accept) begin
      if (v[0]) begin
        r.pc = pc0; r.insn = insn0; r.wen = wen[0]; r.wnum = wn0; r.wdata = wd0;
        r.excp = 1'b0; r.vect = 8'h0; exp_q.push_back(r);
      end
      if (v[1]) begin
        r.pc = pc1; r.insn = insn1; r.wen = wen[1]; r.wnum = wn1; r.wdata = wd1;
        r.excp = 1'b0; r.vect = 8'h0; exp_q.push_back(r);
      end
      if (excp) begin
        r.pc = pc0; r.insn = '0; r.wen = 1'b0; r.wnum = '0; r.wdata = '0;
        r.excp = 1'b1; r.vect = vect; exp_q.push_back(r);
      end
    end
    @(posedge clk); #1;
    i_valid = '0; i_pc = '0; i_insn = '0; i_wen = '0; i_wnum = '0; i_wdata = '0;
    i_excp = 1'b0; i_excp_vect = '0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", exp_q.size() == 0, 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    clk = 0; rst = 1; o_ready = 0; mdl_seq = '0;
    i_valid = '0; i_pc = '0; i_insn = '0; i_wen = '0; i_wnum = '0; i_wdata = '0;
    i_excp = 1'b0; i_excp_vect = '0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    check("rst_valid", o_valid, 0);
    check("rst_seq", o_seq, 0);
    check("rst_ovf", o_overflow, 0);
    check("rst_gap", o_gap_err, 0);
    check("rst_pc", o_pc, 0);

    // single slot
    o_ready = 1;
    send(2'b01, 30'h100, 30'h0, 32'h12345678, 32'h0, 2'b01, 5'd3, 5'd0,
         32'hDEAD, 32'h0, 1'b0, 8'h0, 1);
    drain();
    check("t1_seq", o_seq, 1);
    check("t1_idle", o_valid, 0);

    // dual slot plus exception
    send(2'b11, 30'h200, 30'h201, 32'hA0, 32'hA1, 2'b10, 5'd1, 5'd2,
         32'h11, 32'h22, 1'b1, 8'h1C, 1);
    drain();
    check("t2_seq", o_seq, 4);

    // backpressure
    o_ready = 0;
    send(2'b11, 30'h400, 30'h401, 32'hB0, 32'hB1, 2'b11, 5'd4, 5'd5,
         32'h33, 32'h44, 1'b0, 8'h0, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", o_valid, 1);
      check("bp_pc", o_pc, 30'h400);
      check("bp_wdata", o_wdata, 32'h33);
      check("bp_seq", o_seq, 4);
    end
    @(posedge clk); #1 o_ready = 1;
    @(negedge clk);
    check("rel0_valid", o_valid, 1);
    check("rel0_pc", o_pc, 30'h400);
    @(negedge clk);
    check("rel1_valid", o_valid, 1);
    check("rel1_pc", o_pc, 30'h401);
    drain();
    check("t3_seq", o_seq, 6);

    // overflow: fifth bundle into a full FIFO is dropped
    o_ready = 0;
    for (int i = 0; i < 4; i++)
      send(2'b01, 30'(32'h500 + i), 30'h0, 32'(32'hC0 + i), 32'h0, 2'b01, 5'(i), 5'd0,
           32'(32'h700 + i), 32'h0, 1'b0, 8'h0, 1);
    check("ovf_before", o_overflow, 0);
    send(2'b01, 30'h504, 30'h0, 32'hC4, 32'h0, 2'b01, 5'd4, 5'd0,
         32'h704, 32'h0, 1'b0, 8'h0, 0);
    check("ovf_after", o_overflow, 1);
    o_ready = 1;
    drain();
    repeat (5) @(posedge clk);
    #1;
    check("t4_seq", o_seq, 10);
    check("t4_idle", o_valid, 0);

    // gap in valid mask
    check("gap_before", o_gap_err, 0);
    send(2'b10, 30'h0, 30'h300, 32'h0, 32'hC1, 2'b10, 5'd0, 5'd7,
         32'h0, 32'h55, 1'b0, 8'h0, 1);
    check("gap_after", o_gap_err, 1);
    drain();
    check("t5_seq", o_seq, 11);

    // reset mid-drain
    o_ready = 0;
    send(2'b11, 30'h600, 30'h601, 32'hD0, 32'hD1, 2'b00, 5'd0, 5'd0,
         32'h0, 32'h0, 1'b0, 8'h0, 1);
    o_ready = 1;
    @(posedge clk); #1;
    check("t6_partial", exp_q.size(), 1);
    o_ready = 0; rst = 1;
    exp_q.delete();
    mdl_seq = '0;
    @(posedge clk); #1 rst = 0;
    check("t6_valid", o_valid, 0);
    check("t6_seq", o_seq, 0);
    check("t6_ovf", o_overflow, 0);
    check("t6_gap", o_gap_err, 0);
    o_ready = 1;
    repeat (10) @(posedge clk);
    #1;
    check("t6_idle", o_valid, 0);
    check("t6_seq_end", o_seq, 0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
    $finish;
  end

endmodule
